mem_load_sequencer: RTL and testbench

//  Upstream write-side stage for the 16-sector x 16-word x 16-bit autoencoder memory.

---
 rtl/mem_load_sequencer.sv | 159 +++++++++++++++
 tb/tb_mem_load_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_sequencer.sv
// Write-side sequencer: turns a valid/ready word stream into sector/address write strobes
// for the 16x16x16 memory, filling sectors in order from a base sector (sector 15 is ROM).
module mem_load_sequencer #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_SECTORS  = 15,
   parameter int SECTOR_WORDS = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            base_sector,
   input  logic [7:0]            num_words,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] data_write,
   output logic [3:0]            sector_write_select,
   output logic [3:0]            write_address,
   output logic                  write_enable,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [8:0] LAST_SECTOR = 9'(NUM_SECTORS - 1);
   localparam logic [3:0] LAST_ADDR   = 4'(SECTOR_WORDS - 1);

   state_t                state_q, state_d;
   logic [3:0]            sec_q, sec_d;
   logic [3:0]            addr_q, addr_d;
   logic [7:0]            remaining_q, remaining_d;
   logic [DATA_WIDTH-1:0] data_write_q, data_write_d;
   logic [3:0]            sector_q, sector_d;
   logic [3:0]            address_q, address_d;
   logic                  write_enable_q, write_enable_d;
   logic                  in_ready_q, in_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic [7:0]            span_s;
   logic [8:0]            last_sector_s;
   logic                  bad_range_s;
   logic                  handshake_s;

   // Range check of a requested load and the stream handshake.
   always_comb begin
      span_s        = (num_words - 8'd1) >> 4;
      last_sector_s = {5'd0, base_sector} + {1'b0, span_s};
      bad_range_s   = (num_words == 8'd0) || (last_sector_s > LAST_SECTOR);
      handshake_s   = in_valid & in_ready_q;
   end

   // Next-state and next-output logic; outputs are registered from these values.
   always_comb begin
      state_d        = state_q;
      sec_d          = sec_q;
      addr_d         = addr_q;
      remaining_d    = remaining_q;
      data_write_d   = data_write_q;
      sector_d       = sector_q;
      address_d      = address_q;
      write_enable_d = 1'b0;
      error_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (bad_range_s) begin
                  error_d = 1'b1;
               end else begin
                  state_d     = ST_LOAD;
                  sec_d       = base_sector;
                  addr_d      = 4'd0;
                  remaining_d = num_words;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (handshake_s) begin
               write_enable_d = 1'b1;
               data_write_d   = in_data;
               sector_d       = sec_q;
               address_d      = addr_q;
               remaining_d    = remaining_q - 8'd1;
               // Address wraps at the sector boundary and moves on to the next sector.
               if (addr_q == LAST_ADDR) begin
                  addr_d = 4'd0;
                  sec_d  = sec_q + 4'd1;
               end else begin
                  addr_d = addr_q + 4'd1;
               end
               if (remaining_q == 8'd1) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_LOAD);
      busy_d     = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
      done_d     = (state_d == ST_DONE);
   end

   // State and output registers; reset drops any pending strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         sec_q          <= 4'd0;
         addr_q         <= 4'd0;
         remaining_q    <= 8'd0;
         data_write_q   <= '0;
         sector_q       <= 4'd0;
         address_q      <= 4'd0;
         write_enable_q <= 1'b0;
         in_ready_q     <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         sec_q          <= sec_d;
         addr_q         <= addr_d;
         remaining_q    <= remaining_d;
         data_write_q   <= data_write_d;
         sector_q       <= sector_d;
         address_q      <= address_d;
         write_enable_q <= write_enable_d;
         in_ready_q     <= in_ready_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         error_q        <= error_d;
      end
   end

   assign in_ready            = in_ready_q;
   assign data_write          = data_write_q;
   assign sector_write_select = sector_q;
   assign write_address       = address_q;
   assign write_enable        = write_enable_q;
   assign busy                = busy_q;
   assign done                = done_q;
   assign error               = error_q;

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Self-checking bench for mem_load_sequencer: table of loads, hand-written corner sequences
// and random loads, all compared against a sector/address fill model.
module tb_mem_load_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  base_sector;
   logic [7:0]  num_words;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] data_write;
   logic [3:0]  sector_write_select;
   logic [3:0]  write_address;
   logic        write_enable;
   logic        busy;
   logic        done;
   logic        error;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0]  sec;
      logic [3:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [3:0]  base;
      logic [7:0]  num;
      int          mode;
      logic [15:0] tag;
      bit          err;
      bit          poke;
   } vec_t;

   wr_t         wr_q[$];
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          cyc = 0;
   int          last_hs_cyc = 0;
   int          done_cyc = 0;
   bit          prev_hs = 1'b0;
   logic [15:0] prev_data = 16'd0;

   mem_load_sequencer dut (
      .clock              (clock),
      .reset              (reset),
      .start              (start),
      .base_sector        (base_sector),
      .num_words          (num_words),
      .in_data            (in_data),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .data_write         (data_write),
      .sector_write_select(sector_write_select),
      .write_address      (write_address),
      .write_enable       (write_enable),
      .busy               (busy),
      .done               (done),
      .error              (error)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every accepted word must become exactly one strobe in the following cycle.
   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (prev_hs || (write_enable === 1'b1)) begin
            check("strobe_latency", {31'd0, write_enable}, {31'd0, prev_hs});
            if (prev_hs && (write_enable === 1'b1))
               check("strobe_data", {16'd0, data_write}, {16'd0, prev_data});
         end
         if (write_enable === 1'b1) wr_q.push_back({sector_write_select, write_address, data_write});
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (error === 1'b1) err_cnt++;
         prev_hs   = (in_valid === 1'b1) && (in_ready === 1'b1) && (reset === 1'b0);
         prev_data = in_data;
         if (prev_hs) last_hs_cyc = cyc;
      end
   end

   task automatic run_load(input logic [3:0] b, input logic [7:0] n, input int mode,
                           input logic [15:0] tag, input bit exp_err, input bit poke);
      logic [15:0] words[$];
      int          sent;
      int          iter;
      bit          hs;
      wr_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 16'hDEAD;
         check("idle_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      check("idle_busy", {31'd0, busy}, 32'd0);
      base_sector = b;
      num_words   = n;
      start       = 1'b1;
      in_valid    = 1'b1;
      in_data     = 16'hBEEF;
      check("start_ready", {31'd0, in_ready}, 32'd0);
      tick();
      start       = 1'b0;
      in_valid    = 1'b0;
      base_sector = 4'($urandom);
      num_words   = 8'($urandom);
      if (exp_err) begin
         check("error_pulse", {31'd0, error}, 32'd1);
         check("error_busy", {31'd0, busy}, 32'd0);
         for (int i = 0; i < 3; i++) begin
            tick();
            check("error_idle", {30'd0, busy, in_ready}, 32'd0);
         end
         tick();
         check("error_count", err_cnt, 32'd1);
         check("error_writes", wr_q.size(), 32'd0);
         check("error_done", done_cnt, 32'd0);
      end else begin
         check("load_busy", {31'd0, busy}, 32'd1);
         check("load_no_error", {31'd0, error}, 32'd0);
         sent = 0;
         iter = 0;
         while ((sent < int'(n)) && (iter < 1000)) begin
            if (mode == 0) in_valid = 1'b1;
            else if (mode == 1) in_valid = ((iter % 2) == 0);
            else in_valid = 1'($urandom_range(0, 1));
            in_data = tag + 16'(sent);
            if (poke && (iter == 2)) begin
               start       = 1'b1;
               base_sector = 4'd9;
               num_words   = 8'd3;
            end
            check("load_ready", {31'd0, in_ready}, 32'd1);
            if (in_ready !== 1'b1) break;
            hs = in_valid;
            tick();
            start = 1'b0;
            if (hs) begin
               words.push_back(in_data);
               sent++;
            end
            iter++;
         end
         check("stream_complete", sent, {24'd0, n});
         in_valid = 1'b0;
         check("flush_state", {29'd0, in_ready, busy, write_enable}, 32'd3);
         tick();
         check("done_pulse", {30'd0, done, busy}, 32'd2);
         tick();
         check("done_clear", {29'd0, done, busy, error}, 32'd0);
         tick();
         check("done_count", done_cnt, 32'd1);
         check("done_latency", done_cyc - last_hs_cyc, 32'd2);
         check("write_count", wr_q.size(), {24'd0, n});
         check("error_none", err_cnt, 32'd0);
         for (int i = 0; (i < wr_q.size()) && (i < words.size()); i++)
            check("write_record", {8'd0, wr_q[i]}, {8'd0, 4'(int'(b) + i / 16), 4'(i % 16), words[i]});
      end
   endtask

   initial begin
      vec_t       vecs[12];
      logic [3:0] rb;
      logic [7:0] rn;
      bit         re;
      vecs[0]  = '{4'd0,  8'd16,  0, 16'h1000, 1'b0, 1'b0};
      vecs[1]  = '{4'd2,  8'd20,  0, 16'h2000, 1'b0, 1'b0};
      vecs[2]  = '{4'd14, 8'd17,  0, 16'h3000, 1'b1, 1'b0};
      vecs[3]  = '{4'd5,  8'd0,   0, 16'h3100, 1'b1, 1'b0};
      vecs[4]  = '{4'd1,  8'd5,   1, 16'hA001, 1'b0, 1'b0};
      vecs[5]  = '{4'd14, 8'd16,  2, 16'h4000, 1'b0, 1'b0};
      vecs[6]  = '{4'd0,  8'd240, 0, 16'h5000, 1'b0, 1'b0};
      vecs[7]  = '{4'd0,  8'd241, 0, 16'h5100, 1'b1, 1'b0};
      vecs[8]  = '{4'd15, 8'd1,   0, 16'h5200, 1'b1, 1'b0};
      vecs[9]  = '{4'd13, 8'd32,  2, 16'h6000, 1'b0, 1'b1};
      vecs[10] = '{4'd13, 8'd33,  0, 16'h6100, 1'b1, 1'b0};
      vecs[11] = '{4'd7,  8'd1,   1, 16'h7000, 1'b0, 1'b1};

      reset       = 1'b1;
      start       = 1'b0;
      base_sector = 4'd0;
      num_words   = 8'd0;
      in_data     = 16'd0;
      in_valid    = 1'b0;
      tick();
      check("reset_outputs",
            {in_ready, write_enable, busy, done, error, data_write, sector_write_select, write_address},
            32'd0);
      tick();
      reset = 1'b0;
      tick();

      for (int v = 0; v < 12; v++)
         run_load(vecs[v].base, vecs[v].num, vecs[v].mode, vecs[v].tag, vecs[v].err, vecs[v].poke);

      // Reset in the middle of a load: pending strobe dropped, no done, then a clean reload.
      wr_q.delete();
      done_cnt    = 0;
      base_sector = 4'd3;
      num_words   = 8'd8;
      start       = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 16'hC000 + 16'(i);
         tick();
      end
      reset   = 1'b1;
      in_data = 16'hC003;
      tick();
      check("midload_reset_outputs",
            {in_ready, write_enable, busy, done, error, data_write, sector_write_select, write_address},
            32'd0);
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("midload_no_done", done_cnt, 32'd0);
      check("midload_writes", wr_q.size(), 32'd3);
      for (int i = 0; (i < 3) && (i < wr_q.size()); i++)
         check("midload_record", {8'd0, wr_q[i]}, {8'd0, 4'd3, 4'(i), 16'hC000 + 16'(i)});
      run_load(4'd4, 8'd3, 0, 16'hC100, 1'b0, 1'b0);

      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 4) == 0) begin
            rb = 4'($urandom_range(0, 15));
            rn = 8'($urandom_range(0, 255));
         end else begin
            rb = 4'($urandom_range(0, 14));
            rn = 8'($urandom_range(1, 240 - 16 * int'(rb)));
         end
         re = (rn == 8'd0) || ((int'(rb) + (int'(rn) - 1) / 16) > 14);
         run_load(rb, rn, int'($urandom_range(0, 2)), 16'($urandom), re, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
